// File: rtl/hall98_issuer.sv
// hall98_issuer
// Plays a small loadable program into the hall98 core's instruction
// interface (opcode/re/n/flag). Each legal entry is held on the outputs for
// HOLD cycles. The exit flag is raised when the program finishes or is
// aborted, or when an illegal opcode is reached.
//
// Ports
//   iclock       : sole clock, rising edge
//   irst_n       : asynchronous active-low reset
//   prog_we      : program write strobe (ignored while busy)
//   prog_addr    : program write address
//   prog_opcode  : opcode to store
//   prog_re      : 8-bit register index to store
//   prog_n       : operand to store
//   start        : one-cycle run request (accepted in idle only)
//   run_len      : number of entries to issue, clamped to DEPTH
//   abort        : stop the running program immediately
//   opcode/re/n  : instruction to the core, zero outside the issue state
//   flag         : exit flag to the core
//   busy         : high while issuing
//   done         : one-cycle pulse at the end of a run
//   err          : illegal opcode seen, sticky until the next start
module hall98_issuer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int HOLD  = 10
) (
  input  logic          iclock,
  input  logic          irst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_opcode,
  input  logic [7:0]    prog_re,
  input  logic [31:0]   prog_n,
  input  logic          start,
  input  logic [AW:0]   run_len,
  input  logic          abort,
  output logic [31:0]   opcode,
  output logic [31:0]   re,
  output logic [31:0]   n,
  output logic          flag,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   LEN_ZERO  = (AW+1)'(0);
  localparam logic [AW-1:0] PC_ONE    = AW'(1);
  localparam logic [AW-1:0] PC_ZERO   = AW'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

  // Only MOV/ADD/SUB/MUL/LDR/STR may ever reach the core.
  function automatic logic op_legal(input logic [31:0] op);
    logic ok;
    case (op)
      32'h0000_0045, 32'h0000_0046, 32'h0000_0047,
      32'h0000_0048, 32'h0000_0049, 32'h0000_004A: ok = 1'b1;
      default:                                      ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Entry layout: {opcode[31:0], re[7:0], n[31:0]}
  logic [71:0]   mem_r [DEPTH];

  state_t        state_r;
  logic          launch_r;
  logic [AW-1:0] pc_r;
  logic [CW-1:0] cnt_r;
  logic [AW:0]   len_r;
  logic [31:0]   opcode_r;
  logic [7:0]    re_r;
  logic [31:0]   n_r;
  logic          flag_r;
  logic          busy_r;
  logic          done_r;
  logic          err_r;

  logic [AW-1:0] rd_addr_s;
  logic [71:0]   rd_word_s;
  logic [31:0]   rd_op_s;
  logic          last_s;

  // Program store write port; no reset, contents undefined until loaded.
  always_ff @(posedge iclock) begin
    if (prog_we && !busy_r) begin
      mem_r[prog_addr] <= {prog_opcode, prog_re, prog_n};
    end
  end

  // Read address is the entry the next load edge will put on the outputs:
  // entry 0 while launching from idle, pc+1 while issuing.
  always_comb begin
    rd_addr_s = PC_ZERO;
    if (state_r == ST_ISSUE) begin
      rd_addr_s = pc_r + PC_ONE;
    end else begin
      rd_addr_s = PC_ZERO;
    end
  end

  assign rd_word_s = mem_r[rd_addr_s];
  assign rd_op_s   = rd_word_s[71:40];
  assign last_s    = ({1'b0, pc_r} == (len_r - LEN_ONE));

  // Issue sequencer; every output is a register updated here.
  always_ff @(posedge iclock or negedge irst_n) begin
    if (!irst_n) begin
      state_r  <= ST_IDLE;
      launch_r <= 1'b0;
      pc_r     <= PC_ZERO;
      cnt_r    <= CNT_ZERO;
      len_r    <= LEN_ZERO;
      opcode_r <= 32'h0000_0000;
      re_r     <= 8'h00;
      n_r      <= 32'h0000_0000;
      flag_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (launch_r) begin
            // Second cycle of an accepted start: entry 0 goes out now,
            // which is why a write issued alongside start is seen.
            launch_r <= 1'b0;
            if (op_legal(rd_op_s)) begin
              state_r  <= ST_ISSUE;
              busy_r   <= 1'b1;
              pc_r     <= PC_ZERO;
              cnt_r    <= HOLD_LAST;
              opcode_r <= rd_op_s;
              re_r     <= rd_word_s[39:32];
              n_r      <= rd_word_s[31:0];
            end else begin
              state_r <= ST_FIN;
              done_r  <= 1'b1;
              flag_r  <= 1'b1;
              err_r   <= 1'b1;
            end
          end else if (start) begin
            err_r <= 1'b0;
            if (run_len == LEN_ZERO) begin
              state_r <= ST_FIN;
              done_r  <= 1'b1;
              flag_r  <= 1'b1;
            end else begin
              launch_r <= 1'b1;
              flag_r   <= 1'b0;
              len_r    <= (run_len > DEPTH_L) ? DEPTH_L : run_len;
            end
          end else begin
            launch_r <= 1'b0;
          end
        end

        ST_ISSUE: begin
          // Abort wins over hold expiry; a failing check on the next entry
          // ends the run without that entry ever reaching the outputs.
          if (abort || ((cnt_r == CNT_ZERO) && (last_s || !op_legal(rd_op_s)))) begin
            state_r  <= ST_FIN;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            flag_r   <= 1'b1;
            opcode_r <= 32'h0000_0000;
            re_r     <= 8'h00;
            n_r      <= 32'h0000_0000;
            if (!abort && !last_s) begin
              err_r <= 1'b1;
            end else begin
              err_r <= err_r;
            end
          end else if (cnt_r == CNT_ZERO) begin
            pc_r     <= pc_r + PC_ONE;
            cnt_r    <= HOLD_LAST;
            opcode_r <= rd_op_s;
            re_r     <= rd_word_s[39:32];
            n_r      <= rd_word_s[31:0];
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        ST_FIN: begin
          state_r <= ST_IDLE;
          pc_r    <= PC_ZERO;
          cnt_r   <= CNT_ZERO;
        end

        default: begin
          state_r  <= ST_IDLE;
          launch_r <= 1'b0;
          busy_r   <= 1'b0;
          opcode_r <= 32'h0000_0000;
          re_r     <= 8'h00;
          n_r      <= 32'h0000_0000;
        end
      endcase
    end
  end

  assign opcode = opcode_r;
  assign re     = {24'h00_0000, re_r};
  assign n      = n_r;
  assign flag   = flag_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign err    = err_r;

endmodule

// File: tb/tb_hall98_issuer.sv
// Directed self-checking bench for hall98_issuer (DEPTH=16, HOLD=10).
module tb_hall98_issuer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int HOLD  = 10;

  logic          iclock = 1'b0;
  logic          irst_n = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [31:0]   prog_opcode = '0;
  logic [7:0]    prog_re = '0;
  logic [31:0]   prog_n = '0;
  logic          start = 1'b0;
  logic [AW:0]   run_len = '0;
  logic          abort = 1'b0;
  logic [31:0]   opcode, re, n;
  logic          flag, busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  // Expected program contents (only accepted writes are recorded)
  logic [31:0] m_op [DEPTH];
  logic [7:0]  m_re [DEPTH];
  logic [31:0] m_n  [DEPTH];

  hall98_issuer #(.DEPTH(DEPTH), .AW(AW), .HOLD(HOLD)) dut (
    .iclock(iclock), .irst_n(irst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_opcode(prog_opcode), .prog_re(prog_re), .prog_n(prog_n),
    .start(start), .run_len(run_len), .abort(abort),
    .opcode(opcode), .re(re), .n(n), .flag(flag), .busy(busy),
    .done(done), .err(err)
  );

  always #5 iclock = ~iclock;

  task automatic tick();
    @(posedge iclock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] op, input logic [7:0] r, input logic [31:0] nv);
    prog_we = 1'b1; prog_addr = AW'(a); prog_opcode = op; prog_re = r; prog_n = nv;
    tick();
    prog_we = 1'b0;
    m_op[a] = op; m_re[a] = r; m_n[a] = nv;
  endtask

  task automatic go(input int len);
    start = 1'b1; run_len = (AW+1)'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic chk_fin(input string tag, input logic e);
    chk({tag, "_done"},   32'(done), 32'd1);
    chk({tag, "_flag"},   32'(flag), 32'd1);
    chk({tag, "_busy"},   32'(busy), 32'd0);
    chk({tag, "_err"},    32'(err), 32'(e));
    chk({tag, "_opcode"}, opcode, 32'd0);
    chk({tag, "_re"},     re, 32'd0);
    chk({tag, "_n"},      n, 32'd0);
  endtask

  // Called just after the start edge; walks the whole run and its FIN cycle.
  task automatic run_expect(input string tag, input int n_issue);
    for (int t = 1; t <= n_issue * HOLD; t++) begin
      tick();
      chk({tag, "_opcode"}, opcode, m_op[(t-1)/HOLD]);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done"}, 32'(done), 32'd0);
      if ((t - 1) % HOLD == 0) begin
        chk({tag, "_re"}, re, {24'd0, m_re[(t-1)/HOLD]});
        chk({tag, "_n"},  n,  m_n[(t-1)/HOLD]);
      end
    end
    tick();
    chk_fin(tag, 1'b0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_opcode", opcode, 32'd0);
    chk("rst_re", re, 32'd0);
    chk("rst_n", n, 32'd0);
    chk("rst_flag", 32'(flag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    #3 irst_n = 1'b1;
    tick();

    // Basic 5-entry program
    wr(0, 32'h45, 8'd2, 32'd15);
    wr(1, 32'h45, 8'd3, 32'd5);
    wr(2, 32'h46, 8'd2, 32'd3);
    wr(3, 32'h47, 8'd2, 32'd3);
    wr(4, 32'h48, 8'd2, 32'd3);
    go(5);
    chk("run5_launch_busy", 32'(busy), 32'd0);
    run_expect("run5", 5);
    tick();
    chk("run5_after_done", 32'(done), 32'd0);
    chk("run5_after_flag", 32'(flag), 32'd1);

    // Illegal opcode at entry 2
    wr(0, 32'h45, 8'd1, 32'd7);
    wr(1, 32'h46, 8'd1, 32'd1);
    wr(2, 32'h55, 8'd9, 32'h1234);
    wr(3, 32'h47, 8'd1, 32'd1);
    go(4);
    for (int t = 1; t <= 2 * HOLD; t++) begin
      tick();
      chk("ill_opcode", opcode, m_op[(t-1)/HOLD]);
    end
    tick();
    chk_fin("ill", 1'b1);
    tick();
    chk("ill_err_sticky", 32'(err), 32'd1);
    chk("ill_done_low", 32'(done), 32'd0);
    chk("ill_flag_hold", 32'(flag), 32'd1);

    // Abort at cycle 23 of a 5-entry run
    wr(2, 32'h46, 8'd2, 32'd3);
    go(5);
    chk("abt_err_cleared", 32'(err), 32'd0);
    chk("abt_flag_cleared", 32'(flag), 32'd0);
    for (int t = 1; t <= 22; t++) tick();
    chk("abt_pre_opcode", opcode, m_op[2]);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_fin("abt", 1'b0);
    tick();
    chk("abt_idle_done", 32'(done), 32'd0);
    chk("abt_idle_busy", 32'(busy), 32'd0);

    // run_len = 0, abort in idle
    go(0);
    chk_fin("len0", 1'b0);
    tick();
    chk("len0_done_low", 32'(done), 32'd0);
    chk("len0_flag", 32'(flag), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_done", 32'(done), 32'd0);
    chk("idle_abort_flag", 32'(flag), 32'd1);

    // 3-entry run with a start during busy and a start in the FIN cycle
    go(3);
    for (int t = 1; t <= 3 * HOLD; t++) begin
      start = (t == 5);
      tick();
      start = 1'b0;
      chk("rs_opcode", opcode, m_op[(t-1)/HOLD]);
      chk("rs_done", 32'(done), 32'd0);
    end
    tick();
    chk_fin("rs", 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("finstart_flag", 32'(flag), 32'd1);
    chk("finstart_done", 32'(done), 32'd0);
    tick();
    chk("finstart_busy", 32'(busy), 32'd0);
    chk("finstart_opcode", opcode, 32'd0);

    // Write during busy is ignored
    go(2);
    tick(); tick();
    prog_we = 1'b1; prog_addr = '0; prog_opcode = 32'h4A; prog_re = 8'hFF; prog_n = 32'hFFFF_FFFF;
    tick();
    prog_we = 1'b0;
    repeat (17) tick();
    tick();
    chk_fin("wbusy", 1'b0);
    tick();
    go(1);
    run_expect("old0", 1);
    tick();

    // Write together with start: the run sees the new entry 0
    prog_we = 1'b1; prog_addr = '0; prog_opcode = 32'h49; prog_re = 8'd4; prog_n = 32'd99;
    start = 1'b1; run_len = (AW+1)'(1);
    tick();
    prog_we = 1'b0; start = 1'b0;
    m_op[0] = 32'h49; m_re[0] = 8'd4; m_n[0] = 32'd99;
    run_expect("wrstart", 1);
    tick();

    // Reset in the middle of a run
    go(5);
    repeat (15) tick();
    #3 irst_n = 1'b0;
    #1;
    chk("mrst_opcode", opcode, 32'd0);
    chk("mrst_re", re, 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    #1 irst_n = 1'b1;
    tick();
    chk("mrst_idle_busy", 32'(busy), 32'd0);
    chk("mrst_idle_done", 32'(done), 32'd0);
    go(1);
    run_expect("post_rst", 1);
    tick();

    // run_len clamps to DEPTH
    for (int i = 0; i < DEPTH; i++) begin
      wr(i, 32'h45 + 32'(i % 6), 8'(i), 32'(i * 3));
    end
    go(DEPTH + 1);
    run_expect("clamp", DEPTH);
    tick();
    chk("clamp_after_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
